// File: rtl/alien_fire_scheduler.sv
// Alien swarm fire scheduler: frame cooldown, LFSR column pick, column query, shot-slot launch.
// Build option ALIEN_FIRE_SPEEDUP_EN: cooldown reload shortens as the swarm thins out.
module alien_fire_scheduler #(
    parameter int          NUM_SLOTS     = 3,
    parameter int          NUM_COLS      = 11,
    parameter logic [7:0]  BASE_COOLDOWN = 8'd40,
    parameter logic [10:0] X_OFFSET      = 11'd14,
    parameter logic [10:0] Y_OFFSET      = 11'd16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 playGame,
    input  logic [NUM_SLOTS-1:0] slotFree,
    input  logic                 colAck,
    input  logic                 colHasAlien,
    input  logic [10:0]          colX,
    input  logic [10:0]          colBottomY,
    input  logic [5:0]           aliensLeft,
    output logic                 colReq,
    output logic [3:0]           colIdx,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [10:0]          launchX,
    output logic [10:0]          launchY,
    output logic                 busy
);
    localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
    localparam logic [4:0] COLS_WIDE = 5'(NUM_COLS);

    typedef enum logic [2:0] {IDLE, PICK, QUERY, GAP, CALC, LAUNCH, ABANDON} fireState;

    fireState    stateReg, stateNext;
    logic [9:0]  lfsrReg;
    logic [7:0]  cooldownReg, cooldownNext, reloadValue;
    logic [3:0]  colIdxReg, colIdxNext, triesReg, triesNext, pickIdx;
    logic [10:0] capXReg, capYReg, launchXReg, launchYReg, satX, satY;
    logic [11:0] sumX, sumY;
    logic        captureEn, reloadEn, canFire, inLaunch;

`ifdef ALIEN_FIRE_SPEEDUP_EN
    localparam logic [7:0] HALF_COOLDOWN    = BASE_COOLDOWN >> 1;
    localparam logic [7:0] QUARTER_RAW      = BASE_COOLDOWN >> 2;
    localparam logic [7:0] QUARTER_COOLDOWN = (QUARTER_RAW == 8'd0) ? 8'd1 : QUARTER_RAW;

    always_comb begin
        reloadValue = BASE_COOLDOWN;
        if (aliensLeft < 6'd6)
            reloadValue = QUARTER_COOLDOWN;
        else if (aliensLeft < 6'd16)
            reloadValue = HALF_COOLDOWN;
    end
    // An empty swarm never fires.
    assign canFire = (aliensLeft != 6'd0);
`else
    logic unusedAliens;
    assign unusedAliens = ^aliensLeft;
    assign reloadValue  = BASE_COOLDOWN;
    assign canFire      = 1'b1;
`endif

    // Fold the 4-bit LFSR slice into 0..NUM_COLS-1 with a single subtract.
    assign pickIdx = ({1'b0, lfsrReg[3:0]} >= COLS_WIDE) ? (lfsrReg[3:0] - COLS_WIDE[3:0])
                                                        : lfsrReg[3:0];

    assign sumX = {1'b0, capXReg} + {1'b0, X_OFFSET};
    assign sumY = {1'b0, capYReg} + {1'b0, Y_OFFSET};
    assign satX = sumX[11] ? 11'h7FF : sumX[10:0];
    assign satY = sumY[11] ? 11'h7FF : sumY[10:0];

    always_comb begin
        stateNext  = stateReg;
        colIdxNext = colIdxReg;
        triesNext  = triesReg;
        captureEn  = 1'b0;
        reloadEn   = 1'b0;
        if (!playGame) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (cooldownReg == 8'd0 && |slotFree && canFire)
                        stateNext = PICK;
                end
                PICK: begin
                    colIdxNext = pickIdx;
                    triesNext  = 4'd0;
                    stateNext  = QUERY;
                end
                QUERY: begin
                    if (colAck) begin
                        if (colHasAlien) begin
                            captureEn = 1'b1;
                            stateNext = CALC;
                        end else if (triesReg == LAST_COL) begin
                            stateNext = ABANDON;
                        end else begin
                            triesNext  = triesReg + 4'd1;
                            colIdxNext = (colIdxReg == LAST_COL) ? 4'd0 : colIdxReg + 4'd1;
                            stateNext  = GAP;
                        end
                    end
                end
                GAP:     stateNext = QUERY;
                CALC:    stateNext = LAUNCH;
                LAUNCH, ABANDON: begin
                    reloadEn  = 1'b1;
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Reload takes priority over a coincident frame tick.
    always_comb begin
        cooldownNext = cooldownReg;
        if (!playGame)
            cooldownNext = BASE_COOLDOWN;
        else if (reloadEn)
            cooldownNext = reloadValue;
        else if (startOfFrame && cooldownReg != 8'd0)
            cooldownNext = cooldownReg - 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            lfsrReg     <= 10'h2A5;
            cooldownReg <= BASE_COOLDOWN;
            colIdxReg   <= 4'd0;
            triesReg    <= 4'd0;
            capXReg     <= 11'd0;
            capYReg     <= 11'd0;
            launchXReg  <= 11'd0;
            launchYReg  <= 11'd0;
        end else begin
            stateReg    <= stateNext;
            lfsrReg     <= {lfsrReg[8:0], lfsrReg[9] ^ lfsrReg[6]};
            cooldownReg <= cooldownNext;
            colIdxReg   <= colIdxNext;
            triesReg    <= triesNext;
            if (captureEn) begin
                capXReg <= colX;
                capYReg <= colBottomY;
            end
            launchXReg  <= (stateNext == LAUNCH) ? satX : 11'd0;
            launchYReg  <= (stateNext == LAUNCH) ? satY : 11'd0;
        end
    end

    assign inLaunch = (stateReg == LAUNCH);

    // Lowest-index free slot wins the shot.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gSlot
            if (gi == 0) begin : gFirst
                assign launch[gi] = inLaunch & slotFree[gi];
            end else begin : gRest
                assign launch[gi] = inLaunch & slotFree[gi] & ~|slotFree[gi-1:0];
            end
        end
    endgenerate

    assign colReq  = (stateReg == QUERY);
    assign colIdx  = colIdxReg;
    assign launchX = launchXReg;
    assign launchY = launchYReg;
    assign busy    = (stateReg != IDLE);
endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Self-checking bench for alien_fire_scheduler: directed scenarios plus randomized play
// checked every cycle against a timeline-based reference model.
module tb_alien_fire_scheduler;
    localparam int NS   = 3;
    localparam int NC   = 11;
    localparam int BASE = 40;
    localparam int XOFF = 14;
    localparam int YOFF = 16;

    logic          clk = 1'b0;
    logic          reset, startOfFrame, playGame, colAck, colHasAlien;
    logic [NS-1:0] slotFree;
    logic [10:0]   colX, colBottomY;
    logic [5:0]    aliensLeft;
    logic          colReq, busy;
    logic [3:0]    colIdx;
    logic [NS-1:0] launch;
    logic [10:0]   launchX, launchY;

    always #5 clk = ~clk;

    alien_fire_scheduler #(.NUM_SLOTS(NS), .NUM_COLS(NC)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .playGame(playGame),
        .slotFree(slotFree), .colAck(colAck), .colHasAlien(colHasAlien), .colX(colX),
        .colBottomY(colBottomY), .aliensLeft(aliensLeft), .colReq(colReq), .colIdx(colIdx),
        .launch(launch), .launchX(launchX), .launchY(launchY), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a timeline of one fire attempt ----------------
    int         cyc = 0;
    int         mCool = BASE;
    logic [9:0] mLfsr = 10'h2A5;
    int         mCol = 0, mTries = 0, mLaunchAt = -1, mCapX = 0, mCapY = 0;
    bit         mPick = 0, mQuery = 0, mGap = 0, mAbandon = 0;

    function automatic logic [9:0] lfsrStep(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic int reloadFor(input int al);
`ifdef ALIEN_FIRE_SPEEDUP_EN
        if (al >= 16) return BASE;
        if (al >= 6) return BASE / 2;
        return (BASE / 4 < 1) ? 1 : BASE / 4;
`else
        return (al >= 0) ? BASE : BASE;
`endif
    endfunction

    function automatic bit swarmCanFire(input int al);
`ifdef ALIEN_FIRE_SPEEDUP_EN
        return al != 0;
`else
        return al >= 0;
`endif
    endfunction

    function automatic int sat(input int v, input int off);
        return (v + off > 2047) ? 2047 : v + off;
    endfunction

    function automatic int lowestFree(input logic [NS-1:0] f);
        for (int i = 0; i < NS; i++)
            if (f[i]) return 1 << i;
        return 0;
    endfunction

    function automatic bit modelBusy();
        return mPick || mQuery || mGap || mAbandon || (mLaunchAt >= cyc);
    endfunction

    always @(posedge clk) begin
        int oldCool;
        bit wasIdle, launching, nPick, nQuery, nGap, nAbandon;
        if (reset) begin
            cyc = 0; mCool = BASE; mLfsr = 10'h2A5; mCol = 0; mTries = 0; mLaunchAt = -1;
            mPick = 0; mQuery = 0; mGap = 0; mAbandon = 0;
        end else begin
            oldCool   = mCool;
            wasIdle   = !modelBusy();
            launching = (mLaunchAt == cyc);
            nPick = 0; nQuery = 0; nGap = 0; nAbandon = 0;
            if (!playGame) begin
                mCool     = BASE;
                mLaunchAt = -1;
            end else begin
                if (launching || mAbandon) mCool = reloadFor(int'(aliensLeft));
                else if (startOfFrame && mCool > 0) mCool = mCool - 1;
                nPick  = wasIdle && oldCool == 0 && slotFree != 0 && swarmCanFire(int'(aliensLeft));
                nQuery = mPick || mGap || (mQuery && !colAck);
                if (mPick) begin
                    mCol   = int'(mLfsr[3:0]) % NC;
                    mTries = 0;
                end
                if (mQuery && colAck) begin
                    if (colHasAlien) begin
                        mLaunchAt = cyc + 2;
                        mCapX = int'(colX);
                        mCapY = int'(colBottomY);
                    end else if (mTries == NC - 1) begin
                        nAbandon = 1;
                    end else begin
                        mTries = mTries + 1;
                        mCol   = (mCol + 1) % NC;
                        nGap   = 1;
                    end
                end
                if (launching) mLaunchAt = -1;
            end
            mPick = nPick; mQuery = nQuery; mGap = nGap; mAbandon = nAbandon;
            mLfsr = lfsrStep(mLfsr);
            cyc++;
        end
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        bit lc;
        if (!reset) begin
            lc = (mLaunchAt == cyc);
            chk("m_colReq", 32'(colReq), 32'(mQuery));
            chk("m_colIdx", 32'(colIdx), 32'(mCol));
            chk("m_busy", 32'(busy), 32'(modelBusy()));
            chk("m_launch", 32'(launch), lc ? 32'(lowestFree(slotFree)) : 32'd0);
            chk("m_launchX", 32'(launchX), lc ? 32'(sat(mCapX, XOFF)) : 32'd0);
            chk("m_launchY", 32'(launchY), lc ? 32'(sat(mCapY, YOFF)) : 32'd0);
            if (launch != 0)
                $display("launch cyc=%0d slots=%b x=%0d y=%0d", cyc, launch, launchX, launchY);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic startAttempt();
        int budget;
        frames(40);
        budget = 0;
        while (!colReq && budget < 8) begin
            tick();
            budget++;
        end
        chk("attempt_req", 32'(colReq), 32'd1);
    endtask

    initial begin
        int nq, b, delayLeft;
        bit pend, dryMode;
        reset = 1'b1; startOfFrame = 1'b0; playGame = 1'b0; slotFree = '0;
        colAck = 1'b0; colHasAlien = 1'b0; colX = '0; colBottomY = '0; aliensLeft = 6'd20;
        #1;
        chk("rst_colReq", 32'(colReq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_launch", 32'(launch), 32'd0);
        chk("rst_launchX", 32'(launchX), 32'd0);
        chk("rst_colIdx", 32'(colIdx), 32'd0);
        repeat (3) tick();
        reset = 1'b0; playGame = 1'b1; slotFree = 3'b111;

        // 40 frame pulses, then PICK, then the first request
        for (int i = 0; i < 40; i++) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            chk("pre_fire_busy", 32'(busy), 32'd0);
            chk("pre_fire_launch", 32'(launch), 32'd0);
            tick();
            startOfFrame = 1'b0;
            @(negedge clk);
            chk("pre_fire_req", 32'(colReq), 32'd0);
            if (i < 39) tick();
        end
        tick(); @(negedge clk);
        chk("pick_busy", 32'(busy), 32'd1);
        chk("pick_req", 32'(colReq), 32'd0);
        tick(); @(negedge clk);
        chk("query_req", 32'(colReq), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) begin
                colAck = 1'b1; colHasAlien = 1'b1; colX = 11'd100; colBottomY = 11'd200;
            end
            @(negedge clk);
            chk("query_hold", 32'(colReq), 32'd1);
        end
        tick(); colAck = 1'b0;
        @(negedge clk);
        chk("calc_req", 32'(colReq), 32'd0);
        chk("calc_launch", 32'(launch), 32'd0);
        tick(); @(negedge clk);
        chk("launch_slot", 32'(launch), 32'b001);
        chk("launch_x", 32'(launchX), 32'd114);
        chk("launch_y", 32'(launchY), 32'd216);
        tick(); @(negedge clk);
        chk("post_launch", 32'(launch), 32'd0);
        chk("post_launch_x", 32'(launchX), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);

        // every column empty: 11 queries then abandon
        startAttempt();
        nq = 0;
        while (colReq && nq < 15) begin
            tick();
            colAck = 1'b1; colHasAlien = 1'b0;
            tick();
            colAck = 1'b0;
            b = 0;
            while (!colReq && busy && b < 6) begin
                tick();
                b++;
            end
            nq++;
        end
        chk("abandon_queries", 32'(nq), 32'd11);
        chk("abandon_idle", 32'(busy), 32'd0);
        frames(39);
        tick(); @(negedge clk);
        chk("reload_hold", 32'(busy), 32'd0);
        frames(1); @(negedge clk);
        chk("reload_fire", 32'(busy), 32'd1);

        // saturated position, only the top slot free at launch
        tick();
        colAck = 1'b1; colHasAlien = 1'b1; colX = 11'd2040; colBottomY = 11'd2040;
        tick();
        colAck = 1'b0; slotFree = 3'b100;
        tick(); @(negedge clk);
        chk("slot_high", 32'(launch), 32'b100);
        chk("sat_x", 32'(launchX), 32'h7FF);
        chk("sat_y", 32'(launchY), 32'h7FF);
        tick(); slotFree = 3'b111;

        // no free slot: stays idle with cooldown expired
        slotFree = 3'b000;
        frames(40);
        repeat (4) begin
            @(negedge clk);
            chk("noslot_idle", 32'(busy), 32'd0);
            tick();
        end
        slotFree = 3'b111;
        tick(); @(negedge clk);
        chk("slot_return_pick", 32'(busy), 32'd1);
        tick(); @(negedge clk);
        chk("slot_return_req", 32'(colReq), 32'd1);

        // playGame drop mid-query, late ack ignored
        tick();
        playGame = 1'b0;
        tick();
        playGame = 1'b1; colAck = 1'b1; colHasAlien = 1'b1; colX = 11'd5;
        @(negedge clk);
        chk("drop_req", 32'(colReq), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        tick(); colAck = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_launch", 32'(launch), 32'd0);
            chk("late_ack_busy", 32'(busy), 32'd0);
            tick();
        end

`ifdef ALIEN_FIRE_SPEEDUP_EN
        aliensLeft = 6'd4;
        startAttempt();
        colAck = 1'b1; colHasAlien = 1'b1; colX = 11'd50; colBottomY = 11'd60;
        tick(); colAck = 1'b0;
        tick(); tick();
        aliensLeft = 6'd20;
        frames(9);
        tick(); @(negedge clk);
        chk("speedup_hold", 32'(busy), 32'd0);
        frames(1); @(negedge clk);
        chk("speedup_fire", 32'(busy), 32'd1);
        tick();
`else
        startAttempt();
`endif
        // asynchronous reset during a query
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(colReq), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // randomized play
        pend = 0; delayLeft = 0;
        for (int c = 0; c < 6000; c++) begin
            dryMode = ((c / 500) % 3 == 2);
            startOfFrame = ($urandom_range(0, 1) == 0);
            if (playGame) playGame = ($urandom_range(0, 299) != 0);
            else playGame = ($urandom_range(0, 3) == 0);
            slotFree = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) aliensLeft = 6'($urandom_range(0, 40));
            colAck = 1'b0;
            if (colReq) begin
                if (!pend) begin
                    pend = 1;
                    delayLeft = $urandom_range(0, 3);
                end
                if (delayLeft == 0) begin
                    colAck = 1'b1;
                    colHasAlien = dryMode ? 1'b0 : ($urandom_range(0, 3) != 0);
                    colX = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2020, 2047))
                                                       : 11'($urandom_range(0, 2047));
                    colBottomY = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2020, 2047))
                                                             : 11'($urandom_range(0, 2047));
                    pend = 0;
                end else begin
                    delayLeft--;
                end
            end else begin
                pend = 0;
                colAck = ($urandom_range(0, 15) == 0);
                colHasAlien = 1'b1;
                colX = 11'($urandom_range(0, 2047));
            end
            tick();
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
